// File: rtl/vga_timing_pattern_gen.sv
// VGA timing and test-pattern generator with configurable timing, sync
// polarity and colour depth. A pixel-enable divider sets the pixel rate.
// All video outputs are registered and update only on pixel ticks.
module vga_timing_pattern_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit H_POL      = 1'b0,
  parameter bit V_POL      = 1'b0,
  parameter int PX_DIV     = 4,
  parameter int COLOR_W    = 4,
  parameter int CHECK_LOG2 = 5,
  parameter int GRAD_SHIFT = 5
) (
  input  logic                                                clk,
  input  logic                                                i_sclr,
  input  logic [1:0]                                          i_mode,
  input  logic [3*COLOR_W-1:0]                                i_color,
  output logic                                                o_px_en,
  output logic                                                o_hsync,
  output logic                                                o_vsync,
  output logic                                                o_de,
  output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]        o_x,
  output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]        o_y,
  output logic                                                o_frame_start,
  output logic [COLOR_W-1:0]                                  o_vga_red,
  output logic [COLOR_W-1:0]                                  o_vga_green,
  output logic [COLOR_W-1:0]                                  o_vga_blue
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW      = $clog2(H_TOTAL);
  localparam int YW      = $clog2(V_TOTAL);
  localparam int DW      = (PX_DIV > 1) ? $clog2(PX_DIV) : 1;
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  if (H_ACTIVE % 8 != 0) begin : g_bad_h_active
    $error("vga_timing_pattern_gen: H_ACTIVE must be divisible by 8");
  end
  if (PX_DIV < 1) begin : g_bad_px_div
    $error("vga_timing_pattern_gen: PX_DIV must be at least 1");
  end

  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_GRAD  = 2'd3
  } mode_e;

  logic [DW-1:0]      div_q, div_d;
  logic [XW-1:0]      h_q, h_d;
  logic [YW-1:0]      v_q, v_d;
  logic [BW-1:0]      sub_q, sub_d;
  logic [2:0]         bar_q, bar_d;
  mode_e              mode_q, mode_eff;
  logic               tick;
  int                 h_i, v_i;

  logic               px_en_q, hs_q, vs_q, de_q, fs_q;
  logic [XW-1:0]      x_q;
  logic [YW-1:0]      y_q;
  logic [COLOR_W-1:0] red_q, green_q, blue_q;

  logic               hs_d, vs_d, de_d, fs_d, chk_d;
  logic [COLOR_W-1:0] red_d, green_d, blue_d, grad_d;

  assign h_i  = int'(h_q);
  assign v_i  = int'(v_q);
  assign tick = (int'(div_q) == PX_DIV - 1);

  // Divider, pixel/line counters and the bar sub-counter pair that tracks h.
  always_comb begin
    div_d = tick ? '0 : div_q + 1'b1;
    h_d   = h_q;
    v_d   = v_q;
    sub_d = sub_q;
    bar_d = bar_q;
    if (tick) begin
      if (h_i == H_TOTAL - 1) begin
        h_d   = '0;
        sub_d = '0;
        bar_d = '0;
        v_d   = (v_i == V_TOTAL - 1) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
        if (int'(sub_q) == BAR_W - 1) begin
          sub_d = '0;
          bar_d = bar_q + 1'b1;
        end else begin
          sub_d = sub_q + 1'b1;
        end
      end
    end
  end

  // Timing decode and pattern colour for the pixel at the current counters.
  always_comb begin
    fs_d     = (h_q == '0) && (v_q == '0);
    // The frame's first pixel already uses the mode being latched on it.
    mode_eff = fs_d ? mode_e'(i_mode) : mode_q;
    de_d     = (h_i < H_ACTIVE) && (v_i < V_ACTIVE);
    hs_d     = ((h_i >= H_ACTIVE + H_FP) && (h_i < H_ACTIVE + H_FP + H_SYNC)) ? H_POL : ~H_POL;
    vs_d     = ((v_i >= V_ACTIVE + V_FP) && (v_i < V_ACTIVE + V_FP + V_SYNC)) ? V_POL : ~V_POL;
    chk_d    = (((h_i >> CHECK_LOG2) ^ (v_i >> CHECK_LOG2)) & 1) != 0;
    grad_d   = COLOR_W'(h_i >> GRAD_SHIFT);
    red_d    = '0;
    green_d  = '0;
    blue_d   = '0;
    if (de_d) begin
      case (mode_eff)
        MODE_SOLID: begin
          red_d   = i_color[3*COLOR_W-1:2*COLOR_W];
          green_d = i_color[2*COLOR_W-1:COLOR_W];
          blue_d  = i_color[COLOR_W-1:0];
        end
        MODE_BARS: begin
          // Bar order white..black maps to R=~idx[1], G=~idx[2], B=~idx[0].
          red_d   = {COLOR_W{~bar_q[1]}};
          green_d = {COLOR_W{~bar_q[2]}};
          blue_d  = {COLOR_W{~bar_q[0]}};
        end
        MODE_CHECK: begin
          if (chk_d) begin
            red_d   = i_color[3*COLOR_W-1:2*COLOR_W];
            green_d = i_color[2*COLOR_W-1:COLOR_W];
            blue_d  = i_color[COLOR_W-1:0];
          end
        end
        default: begin
          red_d   = grad_d;
          green_d = grad_d;
          blue_d  = grad_d;
        end
      endcase
    end
  end

  // Counter and latched-mode state.
  always_ff @(posedge clk or posedge i_sclr) begin
    if (i_sclr) begin
      div_q  <= '0;
      h_q    <= '0;
      v_q    <= '0;
      sub_q  <= '0;
      bar_q  <= '0;
      mode_q <= MODE_SOLID;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      sub_q <= sub_d;
      bar_q <= bar_d;
      if (tick && fs_d) mode_q <= mode_e'(i_mode);
    end
  end

  // Registered video outputs, loaded on tick edges and held in between.
  always_ff @(posedge clk or posedge i_sclr) begin
    if (i_sclr) begin
      px_en_q <= 1'b0;
      hs_q    <= ~H_POL;
      vs_q    <= ~V_POL;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      px_en_q <= tick;
      if (tick) begin
        hs_q    <= hs_d;
        vs_q    <= vs_d;
        de_q    <= de_d;
        fs_q    <= fs_d;
        x_q     <= h_q;
        y_q     <= v_q;
        red_q   <= red_d;
        green_q <= green_d;
        blue_q  <= blue_d;
      end
    end
  end

  assign o_px_en       = px_en_q;
  assign o_hsync       = hs_q;
  assign o_vsync       = vs_q;
  assign o_de          = de_q;
  assign o_frame_start = fs_q;
  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_vga_red     = red_q;
  assign o_vga_green   = green_q;
  assign o_vga_blue    = blue_q;

endmodule

// File: tb/tb_vga_timing_pattern_gen.sv
// Bench for vga_timing_pattern_gen: two instances with reduced timing
// (one divided, active-low syncs; one undivided, active-high syncs),
// a pixel-index reference model, directed vectors and random stimulus.
module tb_vga_timing_pattern_gen;

  localparam int HA = 32, HF = 4, HS = 6, HB = 6;
  localparam int VA = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;  // 48
  localparam int VT = VA + VF + VS + VB;  // 19
  localparam int CW = 4, CL = 2, GS = 1;
  localparam int DA = 2, DB = 1;
  localparam int BOUND = HT * VT * DA + 40;

  logic        clk = 1'b0;
  logic        sclr;
  logic [1:0]  mode;
  logic [11:0] color;

  logic       a_pxen, a_hs, a_vs, a_de, a_fs, b_pxen, b_hs, b_vs, b_de, b_fs;
  logic [5:0] a_x, b_x;
  logic [4:0] a_y, b_y;
  logic [3:0] a_r, a_g, a_b, b_r, b_g, b_b;

  int  tests = 0;
  int  fails = 0;
  bit  chk_en = 1'b0;

  vga_timing_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(1'b0), .V_POL(1'b0), .PX_DIV(DA), .COLOR_W(CW),
    .CHECK_LOG2(CL), .GRAD_SHIFT(GS)
  ) dut_a (
    .clk(clk), .i_sclr(sclr), .i_mode(mode), .i_color(color),
    .o_px_en(a_pxen), .o_hsync(a_hs), .o_vsync(a_vs), .o_de(a_de),
    .o_x(a_x), .o_y(a_y), .o_frame_start(a_fs),
    .o_vga_red(a_r), .o_vga_green(a_g), .o_vga_blue(a_b)
  );

  vga_timing_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(1'b1), .V_POL(1'b1), .PX_DIV(DB), .COLOR_W(CW),
    .CHECK_LOG2(CL), .GRAD_SHIFT(GS)
  ) dut_b (
    .clk(clk), .i_sclr(sclr), .i_mode(mode), .i_color(color),
    .o_px_en(b_pxen), .o_hsync(b_hs), .o_vsync(b_vs), .o_de(b_de),
    .o_x(b_x), .o_y(b_y), .o_frame_start(b_fs),
    .o_vga_red(b_r), .o_vga_green(b_g), .o_vga_blue(b_b)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit pxen, hs, vs, de, fs;
    int x, y, rgb;
  } obs_t;

  obs_t ex[2];
  int   ecnt[2];
  int   mlat[2];
  int   bar_rgb[8] = '{7, 6, 3, 2, 5, 4, 1, 0};  // {R,G,B} on/off per bar

  function automatic obs_t reset_obs(input bit hp, input bit vp);
    obs_t o;
    o = '{default: 0};
    o.hs = ~hp;
    o.vs = ~vp;
    return o;
  endfunction

  // Pixel index p = (tick number - 1) fully determines the presented pixel.
  task automatic model_edge(input int d, input int dv, input bit hp, input bit vp);
    int p, h, v, r, g, b, rgb;
    ecnt[d]++;
    ex[d].pxen = (ecnt[d] % dv == 0);
    if (ex[d].pxen) begin
      p = ecnt[d] / dv - 1;
      h = p % HT;
      v = (p / HT) % VT;
      if (h == 0 && v == 0) mlat[d] = int'(mode);
      ex[d].x  = h;
      ex[d].y  = v;
      ex[d].fs = (h == 0 && v == 0);
      ex[d].de = (h < HA && v < VA);
      ex[d].hs = (h >= HA + HF && h < HA + HF + HS) ? hp : ~hp;
      ex[d].vs = (v >= VA + VF && v < VA + VF + VS) ? vp : ~vp;
      r = 0; g = 0; b = 0;
      if (ex[d].de) begin
        case (mlat[d])
          0: begin r = int'(color[11:8]); g = int'(color[7:4]); b = int'(color[3:0]); end
          1: begin
            rgb = bar_rgb[h / (HA / 8)];
            r = ((rgb >> 2) & 1) ? 15 : 0;
            g = ((rgb >> 1) & 1) ? 15 : 0;
            b = (rgb & 1) ? 15 : 0;
          end
          2: if ((((h >> CL) ^ (v >> CL)) & 1) != 0) begin
            r = int'(color[11:8]); g = int'(color[7:4]); b = int'(color[3:0]);
          end
          default: begin r = (h >> GS) % 16; g = r; b = r; end
        endcase
      end
      ex[d].rgb = r * 256 + g * 16 + b;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge sclr);
      if (sclr) begin
        ecnt[0] = 0; ecnt[1] = 0; mlat[0] = 0; mlat[1] = 0;
        ex[0] = reset_obs(1'b0, 1'b0);
        ex[1] = reset_obs(1'b1, 1'b1);
      end else begin
        model_edge(0, DA, 1'b0, 1'b0);
        model_edge(1, DB, 1'b1, 1'b1);
      end
    end
  end

  // Continuous scoreboard, sampled away from the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        cmp("A.ctl", {a_pxen, a_hs, a_vs, a_de, a_fs},
            {ex[0].pxen, ex[0].hs, ex[0].vs, ex[0].de, ex[0].fs});
        cmp("A.x", a_x, ex[0].x);
        cmp("A.y", a_y, ex[0].y);
        cmp("A.rgb", {a_r, a_g, a_b}, ex[0].rgb);
        cmp("B.ctl", {b_pxen, b_hs, b_vs, b_de, b_fs},
            {ex[1].pxen, ex[1].hs, ex[1].vs, ex[1].de, ex[1].fs});
        cmp("B.x", b_x, ex[1].x);
        cmp("B.y", b_y, ex[1].y);
        cmp("B.rgb", {b_r, b_g, b_b}, ex[1].rgb);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_px(input int x, input int y, output bit found);
    found = 1'b0;
    for (int c = 0; c < BOUND && !found; c++) begin
      @(negedge clk);
      if (a_pxen && int'(a_x) == x && int'(a_y) == y) found = 1'b1;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #1 sclr = 1'b1;
    @(negedge clk);
    #1 sclr = 1'b0;
  endtask

  // Called right after reset release: counts edges to A's first px_en.
  task automatic first_tick(input string tag);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(posedge clk);
      n++;
      #1;
      if (n == 1) cmp({tag, ".B_pxen_first"}, b_pxen, 1);
      if (a_pxen) seen = 1'b1;
    end
    cmp({tag, ".A_edges_to_tick"}, seen ? n : 0, DA);
    cmp({tag, ".A_xy0"}, {a_x, a_y}, 0);
    cmp({tag, ".A_fs_de"}, {a_fs, a_de}, 2'b11);
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [11:0] color;
    int          x, y;
    logic [11:0] rgb;
    logic        de, hs, vs;
  } vec_t;

  vec_t tbl[18];
  bit   found;

  initial begin
    tbl[0]  = '{2'd1, 12'h000,  0,  0, 12'hFFF, 1'b1, 1'b1, 1'b1};
    tbl[1]  = '{2'd1, 12'h000,  4,  0, 12'hFF0, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{2'd1, 12'h000, 12,  1, 12'h0F0, 1'b1, 1'b1, 1'b1};
    tbl[3]  = '{2'd1, 12'h000, 16,  2, 12'hF0F, 1'b1, 1'b1, 1'b1};
    tbl[4]  = '{2'd1, 12'h000, 28,  3, 12'h000, 1'b1, 1'b1, 1'b1};
    tbl[5]  = '{2'd1, 12'h000, 40,  0, 12'h000, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{2'd0, 12'hA5C,  5,  5, 12'hA5C, 1'b1, 1'b1, 1'b1};
    tbl[7]  = '{2'd2, 12'hA5C,  0,  0, 12'h000, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{2'd2, 12'hA5C,  4,  0, 12'hA5C, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{2'd2, 12'hA5C,  4,  4, 12'h000, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{2'd2, 12'hA5C,  4, 11, 12'hA5C, 1'b1, 1'b1, 1'b1};
    tbl[11] = '{2'd3, 12'h000,  6,  2, 12'h333, 1'b1, 1'b1, 1'b1};
    tbl[12] = '{2'd3, 12'h000, 31,  0, 12'hFFF, 1'b1, 1'b1, 1'b1};
    tbl[13] = '{2'd0, 12'hA5C, 10, 14, 12'h000, 1'b0, 1'b1, 1'b0};
    tbl[14] = '{2'd0, 12'hA5C, 35, 11, 12'h000, 1'b0, 1'b1, 1'b1};
    tbl[15] = '{2'd0, 12'hA5C, 41,  0, 12'h000, 1'b0, 1'b0, 1'b1};
    tbl[16] = '{2'd0, 12'hA5C, 42, 16, 12'h000, 1'b0, 1'b1, 1'b1};
    tbl[17] = '{2'd0, 12'hA5C, 20, 15, 12'h000, 1'b0, 1'b1, 1'b0};

    sclr  = 1'b1;
    mode  = 2'd0;
    color = 12'h000;
    @(posedge clk);
    #1 chk_en = 1'b1;
    cmp("rst.A_ctl", {a_pxen, a_hs, a_vs, a_de, a_fs}, 5'b01100);
    cmp("rst.B_ctl", {b_pxen, b_hs, b_vs, b_de, b_fs}, 5'b00000);
    cmp("rst.A_xy_rgb", {a_x, a_y, a_r, a_g, a_b}, 0);
    @(negedge clk);
    #1 sclr = 1'b0;
    first_tick("start");

    // Table of directed pixel probes; each starts a fresh frame in its mode.
    for (int i = 0; i < 18; i++) begin
      mode  = tbl[i].mode;
      color = tbl[i].color;
      pulse_reset();
      wait_px(tbl[i].x, tbl[i].y, found);
      cmp($sformatf("tbl%0d.found", i), found, 1);
      cmp($sformatf("tbl%0d.rgb", i), {a_r, a_g, a_b}, tbl[i].rgb);
      cmp($sformatf("tbl%0d.de_hs_vs", i), {a_de, a_hs, a_vs},
          {tbl[i].de, tbl[i].hs, tbl[i].vs});
    end

    // Mid-frame mode change only takes effect on the next frame.
    mode  = 2'd0;
    color = 12'hA5C;
    pulse_reset();
    wait_px(0, 3, found);
    cmp("mid.found0", found, 1);
    #1 mode = 2'd2;
    wait_px(5, 6, found);
    cmp("mid.same_frame", {found, a_r, a_g, a_b}, {1'b1, 12'hA5C});
    wait_px(0, 0, found);
    cmp("mid.next_00", {found, a_r, a_g, a_b}, {1'b1, 12'h000});
    wait_px(4, 0, found);
    cmp("mid.next_40", {found, a_r, a_g, a_b}, {1'b1, 12'hA5C});

    // Asynchronous reset between clock edges, mid-frame.
    wait_px(3, 7, found);
    cmp("async.found", found, 1);
    #2 sclr = 1'b1;
    #1;
    cmp("async.A_ctl", {a_pxen, a_hs, a_vs, a_de, a_fs}, 5'b01100);
    cmp("async.A_xy_rgb", {a_x, a_y, a_r, a_g, a_b}, 0);
    cmp("async.B_ctl", {b_pxen, b_hs, b_vs, b_de, b_fs}, 5'b00000);
    #1 sclr = 1'b0;
    first_tick("async");

    // Random colour every cycle, occasional mode changes and reset glitches.
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      #1;
      color = 12'($urandom);
      if ($urandom_range(0, 99) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 2499) == 0) begin
        sclr = 1'b1;
        #1 sclr = 1'b0;
      end
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vga_timing_pattern_gen.md
Name: vga_timing_pattern_gen

Overview:
Parametrised VGA timing and test-pattern generator. It replaces the fixed 640x480 pixel-clock, hsync, vsync and pattern path with one block that has configurable timing, sync polarity and colour depth. An internal pixel-enable divider generates timing from the system clock. The block produces registered sync, data-enable, pixel coordinates and one of four test patterns, and sits directly in front of the VGA output pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (px)
H_SYNC, 96, hsync width (px)
H_BP, 48, horizontal back porch (px)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, hsync active level (0 = active-low)
V_POL, 0, vsync active level (0 = active-low)
PX_DIV, 4, clk cycles per pixel (>=1)
COLOR_W, 4, bits per colour channel
CHECK_LOG2, 5, checker square size = 2^CHECK_LOG2 px
GRAD_SHIFT, 5, gradient step = 2^GRAD_SHIFT px

Ports:
clk  in  1  system clock
i_sclr  in  1  reset, asynchronous, active-high
i_mode  in  2  pattern select: 0 solid, 1 colour bars, 2 checker, 3 gradient
i_color  in  3*COLOR_W  solid/checker colour {R,G,B}
o_px_en  out  1  one-clk strobe; outputs were updated on the preceding edge
o_hsync  out  1  horizontal sync
o_vsync  out  1  vertical sync
o_de  out  1  active-video flag
o_x  out  clog2(H_TOTAL)  current pixel column
o_y  out  clog2(V_TOTAL)  current line
o_frame_start  out  1  high while o_x=0 and o_y=0 are presented
o_vga_red, o_vga_green, o_vga_blue  out  COLOR_W each  pixel colour

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default); V_TOTAL similarly (525 by default).
- Reset (i_sclr high, async): div_cnt, h_cnt and v_cnt = 0. o_px_en=0, o_de=0, o_frame_start=0, o_x=0, o_y=0, colours=0. o_hsync=~H_POL and o_vsync=~V_POL (inactive). Latched mode = 0.
- Divider: div_cnt counts 0..PX_DIV-1 and wraps. Internal tick = (div_cnt==PX_DIV-1). With PX_DIV=1 the tick is high every cycle.
- On a tick edge:
  - Outputs load values computed from the current h_cnt/v_cnt.
  - h_cnt then increments. At H_TOTAL-1 it wraps to 0 and v_cnt increments. v_cnt wraps at V_TOTAL-1.
  - o_px_en is high for the single clk after each tick edge.
  - Between ticks all outputs hold.
- Decode, on the pre-increment counters:
  - de = h<H_ACTIVE && v<V_ACTIVE.
  - hsync active when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vsync active when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, on whole lines.
  - Active level applies polarity: out = active ? H_POL : ~H_POL (likewise V_POL for vsync).
- Mode latch: i_mode is sampled only on the tick where h=0 and v=0. A mid-frame change takes effect at the next frame. i_color is used live.
- Patterns (colour outputs forced to 0 when de=0):
  - mode 0: {R,G,B} = i_color.
  - mode 1: 8 vertical bars, BAR_W = H_ACTIVE/8 px each. Bars left to right: white, yellow, cyan, green, magenta, red, blue, black, where full = all ones. Bar index comes from a sub-counter/bar counter pair reset at h=0; no divider.
  - mode 2: i_color when x[CHECK_LOG2]^y[CHECK_LOG2]=1, else 0.
  - mode 3: R=G=B = x[GRAD_SHIFT+COLOR_W-1:GRAD_SHIFT] (wraps modulo 2^COLOR_W).
- Reset mid-frame: everything returns immediately to reset values. The first tick after release occurs PX_DIV edges later and presents x=0, y=0 with o_frame_start=1.
- Parameter sanity: H_ACTIVE must be divisible by 8. Simulation asserts on violation.

Test Plan:
- Reset release, defaults -> first o_px_en one clk after 4th edge with o_x=0, o_y=0, o_frame_start=1, o_de=1. o_px_en then repeats every 4 clk.
- Run one line -> o_hsync=0 exactly for x=656..751 (96 px). o_de=1 for x=0..639. Line period 3200 clk.
- Run full frame -> o_vsync=0 on y=490..491 only. o_frame_start period 1,680,000 clk. o_y max 524.
- Mode 1 -> x=0 gives F,F,F; x=80 gives F,F,0; x=560 gives 0,0,0; x=700 gives 0,0,0 (blanking).
- Mode 0→2 written mid-frame with i_color=0xA5C -> rest of frame stays solid A,5,C. Next frame: (x=0,y=0) gives 0,0,0; x=32,y=0 gives A,5,C.
- Async i_sclr pulse at y=200 between clk edges -> outputs reset without a clk edge; restart at (0,0). Repeat with PX_DIV=1 and H_POL=V_POL=1 -> syncs idle low, px_en continuous.
